// File: rtl/fphub_pkg.sv
// Shared types and helpers for the FPHUB arithmetic units (divider today,
// multiplier and square root later).
package fphub_pkg;

    // Operand class as seen by the special-case logic.
    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF
    } fp_class_e;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE,
        ITER,
        PACK,
        OUT
    } div_state_e;

    // Bit positions inside the 4-bit flags word.
    localparam int FLG_INV = 3;
    localparam int FLG_DBZ = 2;
    localparam int FLG_OVF = 1;
    localparam int FLG_UNF = 0;

    // Exponent bias for an e-bit exponent field.
    function automatic int bias(input int e);
        return (1 << (e - 1)) - 1;
    endfunction

endpackage

// File: rtl/fphub_div_special.sv
// Operand classifier and special-case result generator for the HUB divider.
// Purely combinational; the fraction bits never matter for HUB classification.
module fphub_div_special
    import fphub_pkg::*;
#(
    parameter int E = 8,
    parameter int M = 23
) (
    input  logic         xs,
    input  logic [E-1:0] xe,
    input  logic         ds,
    input  logic [E-1:0] de,
    output logic         special,
    output logic [E+M:0] sp_res,
    output logic [3:0]   sp_flags
);

    fp_class_e xc;
    fp_class_e dc;
    logic      s;

    function automatic fp_class_e classify(input logic [E-1:0] e);
        if (e == '0)
            return ZERO;
        else if (&e)
            return INF;
        else
            return NORMAL;
    endfunction

    // Classify both operands and pick the bypass result and its flags.
    always_comb begin
        xc       = classify(xe);
        dc       = classify(de);
        s        = xs ^ ds;
        special  = (xc != NORMAL) || (dc != NORMAL);
        sp_res   = '0;
        sp_flags = '0;
        if (((xc == ZERO) && (dc == ZERO)) || ((xc == INF) && (dc == INF))) begin
            sp_res            = {s, {E{1'b1}}, {M{1'b0}}};
            sp_flags[FLG_INV] = 1'b1;
        end else if ((xc == NORMAL) && (dc == ZERO)) begin
            sp_res            = {s, {E{1'b1}}, {M{1'b0}}};
            sp_flags[FLG_DBZ] = 1'b1;
        end else if ((xc == ZERO) || (dc == INF)) begin
            sp_res = {s, {(E+M){1'b0}}};
        end else if (xc == INF) begin
            sp_res = {s, {E{1'b1}}, {M{1'b0}}};
        end
    end

endmodule

// File: rtl/fphub_srt_div_hs.sv
// Radix-2 SRT divider for HUB floating point. Valid/ready on both sides,
// on-the-fly quotient conversion, tag passthrough and synchronous abort.
module fphub_srt_div_hs
    import fphub_pkg::*;
#(
    parameter int M     = 23,
    parameter int E     = 8,
    parameter int TAG_W = 4,
    parameter int N     = M + 3
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [E+M:0]     x,
    input  logic [E+M:0]     d,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [E+M:0]     res,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       flags
);

    // Fewer than M+3 iterations cannot deliver the normalisation bit plus M
    // fraction bits, so smaller overrides are raised to that minimum.
    localparam int NI = (N < M + 3) ? M + 3 : N;
    localparam int W  = 1 + E + M;
    localparam int WW = M + 5;
    localparam int XW = E + 2;
    localparam int CW = $clog2(NI);
    localparam logic signed [XW-1:0] EXP_BIAS = XW'(bias(E));
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << E) - 1);

    div_state_e              state;
    logic [CW-1:0]           cnt;
    logic signed [WW-1:0]    w;
    logic signed [WW:0]      dd;
    logic [NI-1:0]           q;
    logic [NI-1:0]           qm;
    logic signed [XW-1:0]    ex;
    logic                    sgn;
    logic [TAG_W-1:0]        tag;

    logic                    sp;
    logic [W-1:0]            sp_res;
    logic [3:0]              sp_flags;

    logic signed [WW:0]      w2;
    logic signed [3:0]       y;
    logic [1:0]              qd;
    logic signed [WW-1:0]    w_nx;
    logic                    lead;
    logic [M-1:0]            frac_sel;
    logic signed [XW-1:0]    exp_sel;
    logic [W+3:0]            pk;

    // Clamp an out-of-range biased exponent to signed inf or signed zero.
    function automatic logic [W+3:0] saturate(input logic s,
                                              input logic signed [XW-1:0] e,
                                              input logic [M-1:0] f);
        logic [3:0]   fl;
        logic [W-1:0] r;
        fl = '0;
        r  = {s, e[E-1:0], f};
        if (e >= EXP_MAX) begin
            fl[FLG_OVF] = 1'b1;
            r           = {s, {E{1'b1}}, {M{1'b0}}};
        end else if (e[XW-1] || (e == '0)) begin
            fl[FLG_UNF] = 1'b1;
            r           = {s, {(E+M){1'b0}}};
        end
        return {fl, r};
    endfunction

    fphub_div_special #(
        .E (E),
        .M (M)
    ) u_special (
        .xs       (x[W-1]),
        .xe       (x[W-2 -: E]),
        .ds       (d[W-1]),
        .de       (d[W-2 -: E]),
        .special  (sp),
        .sp_res   (sp_res),
        .sp_flags (sp_flags)
    );

    // Digit selection from the 4-bit estimate of 2w (3 integer bits, 1 fraction bit).
    always_comb begin
        w2 = {w, 1'b0};
        y  = w2[WW -: 4];
        if (y >= 4'sd1) begin
            qd   = 2'b01;
            w_nx = WW'(w2 - dd);
        end else if (y < -4'sd1) begin
            qd   = 2'b11;
            w_nx = WW'(w2 + dd);
        end else begin
            qd   = 2'b00;
            w_nx = WW'(w2);
        end
    end

    // A negative final residual means Q overshot by one ulp; QM already holds Q-1.
    always_comb begin
        lead = w[WW-1] ? qm[NI-1] : q[NI-1];
        if (lead) begin
            frac_sel = w[WW-1] ? qm[NI-2 -: M] : q[NI-2 -: M];
            exp_sel  = ex;
        end else begin
            frac_sel = w[WW-1] ? qm[NI-3 -: M] : q[NI-3 -: M];
            exp_sel  = ex - XW'(1);
        end
        pk = saturate(sgn, exp_sel, frac_sel);
    end

    // Control FSM plus the iteration registers it sequences.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res       <= '0;
            out_tag   <= '0;
            flags     <= '0;
            cnt       <= '0;
            w         <= '0;
            dd        <= '0;
            q         <= '0;
            qm        <= '0;
            ex        <= '0;
            sgn       <= 1'b0;
            tag       <= '0;
        end else if (abort) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            flags     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (sp) begin
                            res       <= sp_res;
                            flags     <= sp_flags;
                            out_tag   <= in_tag;
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end else begin
                            sgn   <= x[W-1] ^ d[W-1];
                            tag   <= in_tag;
                            w     <= {2'b00, 1'b1, x[M-1:0], 1'b1, 1'b0};
                            dd    <= {2'b00, 1'b1, d[M-1:0], 1'b1, 2'b00};
                            ex    <= $signed({2'b00, x[W-2 -: E]})
                                   - $signed({2'b00, d[W-2 -: E]}) + EXP_BIAS;
                            q     <= '0;
                            qm    <= '0;
                            cnt   <= '0;
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    w <= w_nx;
                    case (qd)
                        2'b01: begin
                            q  <= {q[NI-2:0], 1'b1};
                            qm <= {q[NI-2:0], 1'b0};
                        end
                        2'b11: begin
                            q  <= {qm[NI-2:0], 1'b1};
                            qm <= {qm[NI-2:0], 1'b0};
                        end
                        default: begin
                            q  <= {q[NI-2:0], 1'b0};
                            qm <= {qm[NI-2:0], 1'b1};
                        end
                    endcase
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(NI - 1))
                        state <= PACK;
                end
                PACK: begin
                    res       <= pk[W-1:0];
                    flags     <= pk[W+3:W];
                    out_tag   <= tag;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fphub_srt_div_hs.sv
// Directed bench for the HUB SRT divider with default parameters.
module tb_fphub_srt_div_hs;

    localparam int LAT_NORM = 28;
    localparam int LAT_SPEC = 1;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] d;
    logic [3:0]  in_tag;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic [3:0]  out_tag;
    logic [3:0]  flags;

    int checks   = 0;
    int failures = 0;

    // normal-path vectors: x, d, expected quotient, tag
    localparam logic [31:0] NX [4] = '{32'h40C00000, 32'h40400000, 32'hBF800000, 32'h41000000};
    localparam logic [31:0] ND [4] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h3F800000};
    localparam logic [31:0] NR [4] = '{32'h403FFFFF, 32'h3F800000, 32'hBEAAAAAA, 32'h41000000};
    localparam logic [3:0]  NT [4] = '{4'h1, 4'h2, 4'h3, 4'h4};

    // special-path vectors: x, d, expected result, expected flags
    localparam logic [31:0] SX [6] = '{32'h3F800000, 32'h00000000, 32'h00000000,
                                       32'h7F800000, 32'h3F800000, 32'h7F800000};
    localparam logic [31:0] SD [6] = '{32'h00000000, 32'h00000000, 32'hC0000000,
                                       32'h40000000, 32'hFF800000, 32'h7F800000};
    localparam logic [31:0] SR [6] = '{32'h7F800000, 32'h7F800000, 32'h80000000,
                                       32'h7F800000, 32'h80000000, 32'h7F800000};
    localparam logic [3:0]  SF [6] = '{4'b0100, 4'b1000, 4'b0000,
                                       4'b0000, 4'b0000, 4'b1000};

    fphub_srt_div_hs dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .d         (d),
        .in_tag    (in_tag),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .out_tag   (out_tag),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    // Issue one request with out_ready held high; returns the result and the
    // accept-cycle-to-out_valid-cycle latency (200 on timeout).
    task automatic do_op(input logic [31:0] xv, input logic [31:0] dv, input logic [3:0] tv,
                         output logic [31:0] r, output logic [3:0] f, output logic [3:0] t,
                         output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        x = xv; d = dv; in_tag = tv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        r = res; f = flags; t = out_tag;
        if (out_valid) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_l = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
        x = '0; d = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (res !== 32'h0) begin failures++; $display("FAIL reset_res got=%h want=00000000", res); end
        checks++; if (out_tag !== 4'h0) begin failures++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
        checks++; if (flags !== 4'h0) begin failures++; $display("FAIL reset_flags got=%b want=0000", flags); end
        rst_l = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_normal();
        logic [31:0] r;
        logic [3:0]  f;
        logic [3:0]  t;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            do_op(NX[i], ND[i], NT[i], r, f, t, lat);
            checks++; if (r !== NR[i]) begin failures++; $display("FAIL normal%0d_res got=%h want=%h", i, r, NR[i]); end
            checks++; if (f !== 4'b0000) begin failures++; $display("FAIL normal%0d_flags got=%b want=0000", i, f); end
            checks++; if (t !== NT[i]) begin failures++; $display("FAIL normal%0d_tag got=%h want=%h", i, t, NT[i]); end
            checks++; if (lat != LAT_NORM) begin failures++; $display("FAIL normal%0d_latency got=%0d want=%0d", i, lat, LAT_NORM); end
        end
    endtask

    task automatic test_special();
        logic [31:0] r;
        logic [3:0]  f;
        logic [3:0]  t;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            do_op(SX[i], SD[i], 4'(i + 8), r, f, t, lat);
            checks++; if (r !== SR[i]) begin failures++; $display("FAIL special%0d_res got=%h want=%h", i, r, SR[i]); end
            checks++; if (f !== SF[i]) begin failures++; $display("FAIL special%0d_flags got=%b want=%b", i, f, SF[i]); end
            checks++; if (t !== 4'(i + 8)) begin failures++; $display("FAIL special%0d_tag got=%h want=%h", i, t, 4'(i + 8)); end
            checks++; if (lat != LAT_SPEC) begin failures++; $display("FAIL special%0d_latency got=%0d want=%0d", i, lat, LAT_SPEC); end
        end
    endtask

    task automatic test_range();
        logic [31:0] r;
        logic [3:0]  f;
        logic [3:0]  t;
        int          lat;
        do_op(32'h7E800000, 32'h00800001, 4'h6, r, f, t, lat);
        checks++; if (r !== 32'h7F800000) begin failures++; $display("FAIL overflow_res got=%h want=7f800000", r); end
        checks++; if (f !== 4'b0010) begin failures++; $display("FAIL overflow_flags got=%b want=0010", f); end
        checks++; if (lat != LAT_NORM) begin failures++; $display("FAIL overflow_latency got=%0d want=%0d", lat, LAT_NORM); end
        do_op(32'h00800000, 32'h7E800000, 4'h7, r, f, t, lat);
        checks++; if (r !== 32'h00000000) begin failures++; $display("FAIL underflow_res got=%h want=00000000", r); end
        checks++; if (f !== 4'b0001) begin failures++; $display("FAIL underflow_flags got=%b want=0001", f); end
        checks++; if (t !== 4'h7) begin failures++; $display("FAIL underflow_tag got=%h want=7", t); end
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        x = 32'h40400000; d = 32'h40400000; in_tag = 4'hA; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got=%b want=1", out_valid); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (res !== 32'h3F800000) begin failures++; $display("FAIL bp_res_c%0d got=%h want=3f800000", c, res); end
            checks++; if (out_tag !== 4'hA) begin failures++; $display("FAIL bp_tag_c%0d got=%h want=a", c, out_tag); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_c%0d got=%b want=0", c, in_ready); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_c%0d got=%b want=1", c, out_valid); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_after_valid got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_after_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_abort();
        logic [31:0] r;
        logic [3:0]  f;
        logic [3:0]  t;
        int          lat;
        int          n;
        logic        seen;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        x = 32'h40C00000; d = 32'h40000000; in_tag = 4'h3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        abort = 1'b1; in_valid = 1'b1;
        x = 32'h40400000; d = 32'h40400000; in_tag = 4'h9;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid got=%b want=0", out_valid); end
        checks++; if (flags !== 4'h0) begin failures++; $display("FAIL abort_flags got=%b want=0000", flags); end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_result got=%b want=0", seen); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_idle got=%b want=1", in_ready); end
        do_op(32'h40C00000, 32'h40000000, 4'h5, r, f, t, lat);
        checks++; if (r !== 32'h403FFFFF) begin failures++; $display("FAIL abort_next_res got=%h want=403fffff", r); end
        checks++; if (t !== 4'h5) begin failures++; $display("FAIL abort_next_tag got=%h want=5", t); end
        checks++; if (lat != LAT_NORM) begin failures++; $display("FAIL abort_next_latency got=%0d want=%0d", lat, LAT_NORM); end
    endtask

    task automatic test_reset_mid();
        int   n;
        logic seen;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        x = 32'h40400000; d = 32'h40000000; in_tag = 4'hC; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_l = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        checks++; if (res !== 32'h0) begin failures++; $display("FAIL midrst_res got=%h want=00000000", res); end
        checks++; if (out_tag !== 4'h0) begin failures++; $display("FAIL midrst_tag got=%h want=0", out_tag); end
        @(posedge clk); #1;
        rst_l = 1'b1;
        seen = 1'b0;
        repeat (35) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_no_result got=%b want=0", seen); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_range();
        test_backpressure();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
